// File: rtl/imem_burst_loader.sv
// Instruction memory with a registered fetch port and a handshaked debug load port.
// Each accepted debug beat carries LANES words, written one per cycle.
module imem_burst_loader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int LANES  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_debug,
    input  logic                    dbg_valid,
    output logic                    dbg_ready,
    input  logic [ADDR_W-1:0]       debug_address,
    input  logic [LANES*DATA_W-1:0] debug_data,
    input  logic                    fetch_en,
    input  logic [ADDR_W-1:0]       raddress,
    output logic [DATA_W-1:0]       rd,
    output logic                    rd_valid,
    output logic                    load_busy,
    output logic                    load_err,
    output logic [0:0]              fsm_state
);

    // Handshake: a beat transfers on any rising edge where dbg_valid && dbg_ready.
    // dbg_ready never depends on dbg_valid; the source must hold address/data
    // stable while dbg_valid is high and dbg_ready is low.

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [ADDR_W:0]   LAST_OFF  = (ADDR_W + 1)'(LANES - 1);
    localparam logic [ADDR_W:0]   TOP_ADDR  = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t state;
    state_t state_nx;

    logic [DATA_W-1:0]       mem [DEPTH];
    logic [ADDR_W-1:0]       base_q;
    logic [LANES*DATA_W-1:0] data_q;
    logic [LANE_W-1:0]       lane_q;
    logic                    enable_debug_q;

    logic                    accept;
    logic                    last_lane;
    logic                    wraps;
    logic                    fetch_fire;
    logic                    err_clear;
    logic [ADDR_W:0]         beat_end;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;

    assign fsm_state = state;

    // One extra bit so that a beat running past the top address is visible.
    assign beat_end  = {1'b0, debug_address} + LAST_OFF;
    assign wraps     = (beat_end > TOP_ADDR);
    assign last_lane = (lane_q == LAST_LANE);
    assign wr_addr   = base_q + ADDR_W'(lane_q);
    assign wr_data   = data_q[int'(lane_q) * DATA_W +: DATA_W];
    assign err_clear = enable_debug && !enable_debug_q;

    // Fetch only when no beat is in flight and the core owns the memory.
    assign fetch_fire = (state == IDLE) && !enable_debug && fetch_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        dbg_ready = 1'b0;
        load_busy = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                dbg_ready = enable_debug;
                accept    = dbg_valid && enable_debug;
                if (accept) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                load_busy = 1'b1;
                if (last_lane) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q         <= '0;
            data_q         <= '0;
            lane_q         <= '0;
            load_err       <= 1'b0;
            enable_debug_q <= 1'b0;
        end else begin
            enable_debug_q <= enable_debug;
            if (accept) begin
                base_q <= debug_address;
                data_q <= debug_data;
                lane_q <= '0;
            end else if (state == WRITE) begin
                lane_q <= last_lane ? '0 : lane_q + 1'b1;
            end
            // A wrapping beat accepted on the same edge as a re-entry into
            // load mode still reports its error.
            if (accept && wraps) begin
                load_err <= 1'b1;
            end else if (err_clear) begin
                load_err <= 1'b0;
            end
        end
    end

    // Storage is not reset; a reset mid-beat simply stops further lane writes.
    always_ff @(posedge clk) begin
        if (!rst && state == WRITE) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd       <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= fetch_fire;
            if (fetch_fire) begin
                rd <= mem[raddress];
            end
        end
    end

endmodule

// File: tb/tb_imem_burst_loader.sv
// Self-checking bench for imem_burst_loader: scenario tasks driving random beats
// and fetches, compared against a word-addressed memory model.
module tb_imem_burst_loader;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int LANES  = 2;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    enable_debug = 1'b0;
    logic                    dbg_valid = 1'b0;
    logic                    dbg_ready;
    logic [ADDR_W-1:0]       debug_address = '0;
    logic [LANES*DATA_W-1:0] debug_data = '0;
    logic                    fetch_en = 1'b0;
    logic [ADDR_W-1:0]       raddress = '0;
    logic [DATA_W-1:0]       rd;
    logic                    rd_valid;
    logic                    load_busy;
    logic                    load_err;
    logic [0:0]              fsm_state;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] ref_mem [int];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] last_rd = '0;
    logic              ref_err = 1'b0;

    imem_burst_loader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .LANES (LANES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_debug (enable_debug),
        .dbg_valid    (dbg_valid),
        .dbg_ready    (dbg_ready),
        .debug_address(debug_address),
        .debug_data   (debug_data),
        .fetch_en     (fetch_en),
        .raddress     (raddress),
        .rd           (rd),
        .rd_valid     (rd_valid),
        .load_busy    (load_busy),
        .load_err     (load_err),
        .fsm_state    (fsm_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_beat(input logic [ADDR_W-1:0] base,
                                       input logic [LANES*DATA_W-1:0] data,
                                       input int nlanes);
        for (int k = 0; k < nlanes; k++) begin
            ref_mem[(int'(base) + k) % DEPTH] = data[k*DATA_W +: DATA_W];
        end
        if (nlanes == LANES && (int'(base) + LANES - 1 > DEPTH - 1)) begin
            ref_err = 1'b1;
        end
    endfunction

    function automatic logic [LANES*DATA_W-1:0] rand_data();
        logic [LANES*DATA_W-1:0] d;
        for (int k = 0; k < LANES; k++) begin
            d[k*DATA_W +: DATA_W] = $urandom;
        end
        return d;
    endfunction

    // Presents a beat and returns right after the edge that accepted it.
    task automatic send_beat(input logic [ADDR_W-1:0] base, input logic [LANES*DATA_W-1:0] data);
        int n = 0;
        debug_address = base;
        debug_data    = data;
        dbg_valid     = 1'b1;
        while (!dbg_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (dbg_ready !== 1'b1) begin
            errors++;
            $display("FAIL beat_accept: dbg_ready=%b required 1 (base %h)", dbg_ready, base);
        end
        tick();
        dbg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (load_busy && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (load_busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: load_busy=%b required 0", load_busy);
        end
    endtask

    // Scoreboard: expected fetch data is queued from the model before the edge.
    task automatic fetch_check(input logic [ADDR_W-1:0] addr, input string name);
        logic [DATA_W-1:0] exp;
        fetch_en = 1'b1;
        raddress = addr;
        exp_q.push_back(ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : '0);
        tick();
        fetch_en = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s rd_valid: got %b required 1", name, rd_valid);
        end
        checks++;
        if (rd !== exp) begin
            errors++;
            $display("FAIL %s rd @%h: got %h required %h", name, addr, rd, exp);
        end
        last_rd = exp;
    endtask

    // Scenarios.
    task automatic test_reset();
        rst = 1'b1;
        enable_debug = 1'b0;
        tick();
        tick();
        checks++; if (rd !== '0) begin errors++; $display("FAIL reset_rd: got %h required 0", rd); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b required 0", rd_valid); end
        checks++; if (dbg_ready !== 1'b0) begin errors++; $display("FAIL reset_dbg_ready: got %b required 0", dbg_ready); end
        checks++; if (load_busy !== 1'b0) begin errors++; $display("FAIL reset_load_busy: got %b required 0", load_busy); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err: got %b required 0", load_err); end
        rst = 1'b0;
        tick();
        last_rd = '0;
    endtask

    task automatic test_basic_load();
        logic [LANES*DATA_W-1:0] d;
        d = {32'h2222_2222, 32'h1111_1111};
        enable_debug = 1'b1;
        tick();
        send_beat(9'h010, d);
        model_beat(9'h010, d, LANES);
        for (int c = 0; c < LANES; c++) begin
            checks++;
            if (dbg_ready !== 1'b0 || load_busy !== 1'b1) begin
                errors++;
                $display("FAIL load_busy_cycle%0d: dbg_ready=%b load_busy=%b required 0/1", c, dbg_ready, load_busy);
            end
            tick();
        end
        checks++;
        if (dbg_ready !== 1'b1 || load_busy !== 1'b0) begin
            errors++;
            $display("FAIL load_done: dbg_ready=%b load_busy=%b required 1/0", dbg_ready, load_busy);
        end
        enable_debug = 1'b0;
        tick();
        fetch_check(9'h010, "basic_lane0");
        fetch_check(9'h011, "basic_lane1");
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_rd_valid: got %b required 0", rd_valid);
        end
    endtask

    task automatic test_wrap();
        logic [LANES*DATA_W-1:0] d;
        d = rand_data();
        enable_debug = 1'b1;
        tick();
        send_beat(9'h1FF, d);
        model_beat(9'h1FF, d, LANES);
        checks++;
        if (load_err !== ref_err) begin
            errors++;
            $display("FAIL wrap_err_set: got %b required %b", load_err, ref_err);
        end
        wait_idle();
        for (int c = 0; c < 3; c++) tick();
        checks++;
        if (load_err !== 1'b1) begin
            errors++;
            $display("FAIL wrap_err_held: got %b required 1", load_err);
        end
        enable_debug = 1'b0;
        tick();
        checks++;
        if (load_err !== 1'b1) begin
            errors++;
            $display("FAIL wrap_err_after_fall: got %b required 1", load_err);
        end
        fetch_check(9'h1FF, "wrap_top");
        fetch_check(9'h000, "wrap_bottom");
        enable_debug = 1'b1;
        tick();
        ref_err = 1'b0;
        checks++;
        if (load_err !== ref_err) begin
            errors++;
            $display("FAIL wrap_err_clear: got %b required %b", load_err, ref_err);
        end
    endtask

    task automatic test_fetch_blocked();
        enable_debug = 1'b1;
        for (int c = 0; c < 5; c++) begin
            fetch_en = 1'b1;
            raddress = ADDR_W'($urandom_range(0, DEPTH - 1));
            tick();
            checks++;
            if (rd_valid !== 1'b0 || rd !== last_rd) begin
                errors++;
                $display("FAIL blocked_fetch%0d: rd_valid=%b rd=%h required 0 and %h", c, rd_valid, rd, last_rd);
            end
        end
        fetch_en = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        logic [LANES*DATA_W-1:0] d_old;
        logic [LANES*DATA_W-1:0] d_new;
        d_old = rand_data();
        d_new = rand_data();
        enable_debug = 1'b1;
        tick();
        send_beat(9'h020, d_old);
        model_beat(9'h020, d_old, LANES);
        wait_idle();
        send_beat(9'h020, d_new);
        tick();
        model_beat(9'h020, d_new, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_rd = '0;
        checks++;
        if (load_busy !== 1'b0 || rd_valid !== 1'b0 || rd !== '0) begin
            errors++;
            $display("FAIL midreset_state: load_busy=%b rd_valid=%b rd=%h required 0/0/0", load_busy, rd_valid, rd);
        end
        enable_debug = 1'b0;
        tick();
        fetch_check(9'h020, "midreset_lane0_new");
        fetch_check(9'h021, "midreset_lane1_old");
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0]       bases [3];
        logic [LANES*DATA_W-1:0] datas [3];
        int acc_cyc [3];
        int idx = 0;
        int cyc = 0;
        for (int i = 0; i < 3; i++) begin
            bases[i] = ADDR_W'($urandom_range(9'h040, 9'h1F0));
            datas[i] = rand_data();
        end
        enable_debug = 1'b1;
        tick();
        dbg_valid = 1'b1;
        while (idx < 3 && cyc < 40) begin
            debug_address = bases[idx];
            debug_data    = datas[idx];
            if (dbg_ready) begin
                acc_cyc[idx] = cyc;
                model_beat(bases[idx], datas[idx], LANES);
                idx++;
            end
            tick();
            cyc++;
        end
        dbg_valid = 1'b0;
        checks++;
        if (idx != 3) begin
            errors++;
            $display("FAIL b2b_count: accepted %0d beats required 3", idx);
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (acc_cyc[i] - acc_cyc[i-1] != LANES + 1) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles required %0d", i, acc_cyc[i] - acc_cyc[i-1], LANES + 1);
                end
            end
        end
        wait_idle();
        checks++;
        if (load_err !== ref_err) begin
            errors++;
            $display("FAIL b2b_err: got %b required %b", load_err, ref_err);
        end
        enable_debug = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < LANES; k++) begin
                fetch_check(bases[i] + ADDR_W'(k), "b2b_readback");
            end
        end
    endtask

    task automatic test_drop_mid_beat();
        logic [ADDR_W-1:0]       base;
        logic [LANES*DATA_W-1:0] d;
        logic [DATA_W-1:0]       exp;
        base = ADDR_W'($urandom_range(9'h100, 9'h1F0));
        d = rand_data();
        enable_debug = 1'b1;
        tick();
        send_beat(base, d);
        model_beat(base, d, LANES);
        enable_debug = 1'b0;
        fetch_en = 1'b1;
        raddress = base;
        for (int c = 0; c < LANES; c++) begin
            tick();
            checks++;
            if (rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL drop_fetch_blocked%0d: rd_valid=%b required 0", c, rd_valid);
            end
        end
        exp = ref_mem[int'(base)];
        tick();
        fetch_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd !== exp) begin
            errors++;
            $display("FAIL drop_first_fetch: rd_valid=%b rd=%h required 1 and %h", rd_valid, rd, exp);
        end
        checks++;
        if (dbg_ready !== 1'b0) begin
            errors++;
            $display("FAIL drop_dbg_ready: got %b required 0", dbg_ready);
        end
        fetch_check(base + ADDR_W'(LANES - 1), "drop_last_lane");
    endtask

    // Sequence and final report.
    initial begin
        test_reset();
        test_basic_load();
        test_wrap();
        test_fetch_blocked();
        test_reset_mid_write();
        test_back_to_back();
        test_drop_mid_beat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
